i2c_byte_tx: RTL

I2C target-side byte transmitter. It is the outbound counterpart of the SDA/SCL input synchronizers. It takes a parallel byte from the controller logic and shifts it MSB-first onto the open-drain SDA line, timed to the already-synchronized SCL. It then releases SDA and samples the bus controller's ACK/NACK. The block sits between the I2C target FSM and the SDA pad output enable.

---
 rtl/i2c_byte_tx.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/i2c_byte_tx.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_byte_tx
//  Purpose  : I2C target byte transmitter. Shifts a byte MSB-first onto the
//             open-drain SDA line against synchronized SCL, then samples ACK.
//             Optional drive-back bit check enabled by I2C_TX_BITCHK_EN.
//  Revision : 1.0  initial release
// ============================================================================
module i2c_byte_tx #(
    parameter int DATA_W      = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              scl_in,
    input  logic              sda_in,
    input  logic              stop_found,
    input  logic              tx_start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              sda_out,
    output logic              tx_busy,
    output logic              byte_done,
`ifdef I2C_TX_BITCHK_EN
    output logic              bit_err,
`endif
    output logic              ack_rcvd
);

    localparam int             C_CNT_W     = $clog2(DATA_W + 1);
    localparam logic [3:0]     C_HOLD_LAST = 4'(HOLD_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_BITS  = C_CNT_W'(DATA_W);
    localparam logic [C_CNT_W-1:0] C_ONE   = C_CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_HOLD     = 3'd1,
        S_DRIVE    = 3'd2,
        S_ACK_HOLD = 3'd3,
        S_ACK_WAIT = 3'd4
    } state_t;

    state_t              r_state;
    logic                r_scl_prev;
    logic [DATA_W-1:0]   r_shreg;
    logic [C_CNT_W-1:0]  r_bit_cnt;
    logic [3:0]          r_hold_cnt;

    logic w_fall;
    logic w_rise;

    assign w_fall = r_scl_prev & ~scl_in;
    assign w_rise = ~r_scl_prev & scl_in;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= S_IDLE;
            r_scl_prev <= 1'b0;
            r_shreg    <= '0;
            r_bit_cnt  <= '0;
            r_hold_cnt <= '0;
            sda_out    <= 1'b1;
            tx_busy    <= 1'b0;
            byte_done  <= 1'b0;
            ack_rcvd   <= 1'b0;
`ifdef I2C_TX_BITCHK_EN
            bit_err    <= 1'b0;
`endif
        end else begin
            r_scl_prev <= scl_in;
            byte_done  <= 1'b0;
`ifdef I2C_TX_BITCHK_EN
            bit_err    <= 1'b0;
`endif
            // A bus STOP / repeated START aborts everything, including a same-cycle start
            if (stop_found) begin
                r_state <= S_IDLE;
                sda_out <= 1'b1;
                tx_busy <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        sda_out <= 1'b1;
                        if (tx_start) begin
                            r_shreg    <= tx_data;
                            r_bit_cnt  <= C_BITS;
                            r_hold_cnt <= '0;
                            tx_busy    <= 1'b1;
                            r_state    <= S_HOLD;
                        end
                    end
                    S_HOLD: begin
                        if (r_hold_cnt == C_HOLD_LAST) begin
                            sda_out <= r_shreg[DATA_W-1];
                            r_state <= S_DRIVE;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 4'd1;
                        end
                    end
                    S_DRIVE: begin
`ifdef I2C_TX_BITCHK_EN
                        // Released line read back low means another driver won the bus
                        if (w_rise && sda_out && !sda_in) begin
                            bit_err <= 1'b1;
                            sda_out <= 1'b1;
                            tx_busy <= 1'b0;
                            r_state <= S_IDLE;
                        end else
`endif
                        if (w_fall) begin
                            r_shreg    <= {r_shreg[DATA_W-2:0], 1'b0};
                            r_bit_cnt  <= r_bit_cnt - C_ONE;
                            r_hold_cnt <= '0;
                            r_state    <= (r_bit_cnt == C_ONE) ? S_ACK_HOLD : S_HOLD;
                        end
                    end
                    S_ACK_HOLD: begin
                        if (r_hold_cnt == C_HOLD_LAST) begin
                            sda_out <= 1'b1;
                            r_state <= S_ACK_WAIT;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 4'd1;
                        end
                    end
                    S_ACK_WAIT: begin
                        if (w_rise) begin
                            ack_rcvd  <= ~sda_in;
                            byte_done <= 1'b1;
                            tx_busy   <= 1'b0;
                            r_state   <= S_IDLE;
                        end
                    end
                    default: begin
                        sda_out <= 1'b1;
                        tx_busy <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
